// File: rtl/goose_sprite.sv
// Bouncing, two-frame animated goose sprite (16x16 bitmap drawn at 2x) for the VGA colour mux.
// Motion and animation advance once per frame at the start of vblank; pixel outputs are registered.
`timescale 1ns/1ps
module goose_sprite #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned SPRITE_W = 32,
  parameter int unsigned SPRITE_H = 32,
  parameter int unsigned STEP_X   = 2,
  parameter int unsigned STEP_Y   = 1,
  parameter int unsigned X0       = 64,
  parameter int unsigned Y0       = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       video_active,
  input  logic       freeze,
  output logic       in_goose,
  output logic [1:0] goose_R,
  output logic [1:0] goose_G,
  output logic [1:0] goose_B
);

  localparam logic [9:0] X_MAX = 10'(H_ACTIVE - SPRITE_W);
  localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - SPRITE_H);
  localparam logic [9:0] SX    = 10'(STEP_X);
  localparam logic [9:0] SY    = 10'(STEP_Y);
  localparam logic [9:0] SW    = 10'(SPRITE_W);
  localparam logic [9:0] SH    = 10'(SPRITE_H);
  localparam logic [9:0] VA    = 10'(V_ACTIVE);
  localparam logic [9:0] X_RST = 10'(X0);
  localparam logic [9:0] Y_RST = 10'(Y0);

  // One row of the bitmap: column c occupies bits [2c+1:2c]; art faces right.
  function automatic logic [31:0] rom_row(input logic frame, input logic [3:0] row);
    logic [31:0] bits;
    case (row)
      4'd0, 4'd2:               bits = 32'h02A0_0000;
      4'd1:                     bits = 32'h3EA0_0000;
      4'd3, 4'd4, 4'd5, 4'd6:   bits = 32'h0080_0000;
      4'd7:                     bits = 32'h0195_5550;
      4'd8:                     bits = 32'h5555_5555;
      4'd9:                     bits = 32'h0555_5554;
      4'd10:                    bits = 32'h0155_5550;
      4'd11:                    bits = 32'h0055_5540;
      4'd12:                    bits = 32'h0005_5400;
      4'd13:                    bits = 32'h0004_1000;
      4'd14:                    bits = frame ? 32'h0030_0C00 : 32'h000C_3000;
      default:                  bits = frame ? 32'h00F0_0F00 : 32'h000F_3C00;
    endcase
    return bits;
  endfunction

  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic [2:0]  frame_cnt_q, frame_cnt_d;
  logic        anim_q, anim_d;
  logic        in_goose_q, in_goose_d;
  logic [5:0]  rgb_q, rgb_d;

  logic        frame_tick;
  logic        hit;
  logic [3:0]  row, col;
  logic [31:0] row_bits;
  logic [1:0]  idx;
  logic [5:0]  pal;

  always_comb begin
    frame_tick  = (pix_x == 10'd0) && (pix_y == VA);
    x_d         = x_q;
    y_d         = y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    frame_cnt_d = frame_cnt_q;
    anim_d      = anim_q;

    if (frame_tick && !freeze) begin
      if (dx_q) begin
        if (x_q + SX >= X_MAX) begin
          x_d  = X_MAX;
          dx_d = 1'b0;
        end else begin
          x_d = x_q + SX;
        end
      end else if (x_q <= SX) begin
        x_d  = '0;
        dx_d = 1'b1;
      end else begin
        x_d = x_q - SX;
      end

      if (dy_q) begin
        if (y_q + SY >= Y_MAX) begin
          y_d  = Y_MAX;
          dy_d = 1'b0;
        end else begin
          y_d = y_q + SY;
        end
      end else if (y_q <= SY) begin
        y_d  = '0;
        dy_d = 1'b1;
      end else begin
        y_d = y_q - SY;
      end

      frame_cnt_d = frame_cnt_q + 3'd1;
      if (frame_cnt_q == 3'd7) anim_d = ~anim_q;
    end

    hit = (pix_x >= x_q) && (pix_x < x_q + SW) && (pix_y >= y_q) && (pix_y < y_q + SH);
    row = 4'((pix_y - y_q) >> 1);
    col = 4'((pix_x - x_q) >> 1);
    if (!dx_q) col = 4'd15 - col;
    row_bits = rom_row(anim_q, row);
    idx      = row_bits[{col, 1'b0} +: 2];

    case (idx)
      2'd1:    pal = 6'b11_11_11;
      2'd3:    pal = 6'b11_10_00;
      default: pal = 6'b00_00_00;
    endcase

    in_goose_d = video_active && hit && (idx != 2'd0);
    rgb_d      = in_goose_d ? pal : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= X_RST;
      y_q         <= Y_RST;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      frame_cnt_q <= '0;
      anim_q      <= 1'b0;
      in_goose_q  <= 1'b0;
      rgb_q       <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      frame_cnt_q <= frame_cnt_d;
      anim_q      <= anim_d;
      in_goose_q  <= in_goose_d;
      rgb_q       <= rgb_d;
    end
  end

  assign in_goose = in_goose_q;
  assign goose_R  = rgb_q[5:4];
  assign goose_G  = rgb_q[3:2];
  assign goose_B  = rgb_q[1:0];

endmodule

// File: tb/tb_goose_sprite.sv
// Scoreboard bench for goose_sprite: probes push expected pixels, a monitor pops and compares one cycle later.
`timescale 1ns/1ps
module tb_goose_sprite;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic       video_active = 1'b0;
  logic       freeze = 1'b0;
  logic       in_goose;
  logic [1:0] goose_R, goose_G, goose_B;

  always #5 clk = ~clk;

  goose_sprite #(
    .H_ACTIVE(640), .V_ACTIVE(480), .SPRITE_W(32), .SPRITE_H(32),
    .STEP_X(2), .STEP_Y(1), .X0(64), .Y0(48)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .video_active(video_active), .freeze(freeze), .in_goose(in_goose),
    .goose_R(goose_R), .goose_G(goose_G), .goose_B(goose_B)
  );

  // {in_goose, R, G, B}
  localparam logic [6:0] NONE   = 7'b0_00_00_00;
  localparam logic [6:0] WHITE  = 7'b1_11_11_11;
  localparam logic [6:0] BLACK  = 7'b1_00_00_00;
  localparam logic [6:0] YELLOW = 7'b1_11_10_00;

  logic [6:0] exp_q[$];
  string      nm_q[$];
  logic       probe_req = 1'b0;
  logic       out_vld;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         t_cnt = 0;

  task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_vld <= 1'b0;
    else        out_vld <= probe_req;
  end

  always @(negedge clk) begin
    if (out_vld) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty: got output with no expectation queued");
      end else begin
        check(nm_q.pop_front(), {in_goose, goose_R, goose_G, goose_B}, exp_q.pop_front());
      end
    end
  end

  task automatic probe(input logic [9:0] px, input logic [9:0] py, input logic va,
                       input logic [6:0] e, input string nm);
    @(negedge clk);
    pix_x = px;
    pix_y = py;
    video_active = va;
    probe_req = 1'b1;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic tick();
    @(negedge clk);
    probe_req = 1'b0;
    pix_x = 10'd0;
    pix_y = 10'd480;
    video_active = 1'b0;
    @(negedge clk);
    pix_x = 10'd1;
    if (!freeze) t_cnt++;
  endtask

  task automatic run_to(input int t);
    while (t_cnt < t) tick();
  endtask

  // Probe points chosen so the answer pins x, y, facing and leg frame.
  task automatic check_pos(input logic [9:0] x, input logic [9:0] y, input logic dx,
                           input logic anim, input string tag);
    probe(x - 10'd1,  y + 10'd16, 1'b1, NONE,                $sformatf("%s.left_out", tag));
    probe(x,          y + 10'd16, 1'b1, WHITE,               $sformatf("%s.left_in", tag));
    probe(x + 10'd31, y + 10'd16, 1'b1, WHITE,               $sformatf("%s.right_in", tag));
    probe(x + 10'd32, y + 10'd16, 1'b1, NONE,                $sformatf("%s.right_out", tag));
    probe(x + 10'd16, y + 10'd13, 1'b1, NONE,                $sformatf("%s.row6", tag));
    probe(x + 10'd16, y + 10'd14, 1'b1, WHITE,               $sformatf("%s.row7", tag));
    probe(x + 10'd22, y,          1'b1, dx ? BLACK : NONE,   $sformatf("%s.head_r", tag));
    probe(x + 10'd8,  y,          1'b1, dx ? NONE : BLACK,   $sformatf("%s.head_l", tag));
    probe(x + 10'd26, y + 10'd2,  1'b1, dx ? YELLOW : NONE,  $sformatf("%s.beak_r", tag));
    probe(x + 10'd4,  y + 10'd2,  1'b1, dx ? NONE : YELLOW,  $sformatf("%s.beak_l", tag));
    probe(x + 10'd8,  y + 10'd30, 1'b1, anim ? YELLOW : NONE, $sformatf("%s.leg_out", tag));
    probe(x + 10'd12, y + 10'd30, 1'b1, anim ? NONE : YELLOW, $sformatf("%s.leg_in", tag));
  endtask

  initial begin
    #1 check("por_outputs", {in_goose, goose_R, goose_G, goose_B}, NONE);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check_pos(10'd64, 10'd48, 1'b1, 1'b0, "reset");
    probe(10'd80, 10'd64, 1'b1, WHITE, "t2_body");
    probe(10'd64, 10'd48, 1'b1, NONE,  "t2_corner");

    // Async reset mid-line while the sprite is being drawn
    run_to(5);
    probe(10'd90, 10'd69, 1'b1, WHITE, "pre_reset");
    @(negedge clk);
    probe_req = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("reset_async", {in_goose, goose_R, goose_G, goose_B}, NONE);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t_cnt = 0;
    check_pos(10'd64, 10'd48, 1'b1, 1'b0, "rearm");

    // Freeze holds everything across many frame ticks
    run_to(3);
    freeze = 1'b1;
    repeat (20) tick();
    check_pos(10'd70, 10'd51, 1'b1, 1'b0, "frozen");
    freeze = 1'b0;
    run_to(4);
    check_pos(10'd72, 10'd52, 1'b1, 1'b0, "unfrozen");

    run_to(7);   check_pos(10'd78,  10'd55,  1'b1, 1'b0, "t7");
    run_to(8);   check_pos(10'd80,  10'd56,  1'b1, 1'b1, "t8");
    run_to(271); check_pos(10'd606, 10'd319, 1'b1, 1'b1, "t271");
    run_to(272); check_pos(10'd608, 10'd320, 1'b0, 1'b0, "t272");
    run_to(273); check_pos(10'd606, 10'd321, 1'b0, 1'b0, "t273");
    run_to(400); check_pos(10'd352, 10'd448, 1'b0, 1'b0, "t400");
    run_to(401); check_pos(10'd350, 10'd447, 1'b0, 1'b0, "t401");
    run_to(576); check_pos(10'd0,   10'd272, 1'b1, 1'b0, "t576");
    run_to(577); check_pos(10'd2,   10'd271, 1'b1, 1'b0, "t577");
    run_to(848); check_pos(10'd544, 10'd0,   1'b1, 1'b0, "t848");
    run_to(849); check_pos(10'd546, 10'd1,   1'b1, 1'b0, "t849");

    probe(10'd562, 10'd17, 1'b0, NONE,  "va_off");
    probe(10'd562, 10'd17, 1'b1, WHITE, "va_on");

    // Rest of the vblank line must not move the sprite again
    for (int i = 1; i < 640; i++) begin
      @(negedge clk);
      probe_req = 1'b0;
      pix_x = 10'(i);
      pix_y = 10'd480;
      video_active = 1'b0;
    end
    check_pos(10'd546, 10'd1, 1'b1, 1'b0, "scan");

    @(negedge clk);
    probe_req = 1'b0;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
